// File: rtl/des_key_pkg.sv
// des_key_pkg
//   Shared types, constants and helper functions for the DES key schedule
//   controller: FSM state encoding, round count, per-round shift table,
//   PC-1 / PC-2 selection tables and the 28-bit rotate.
//   Bit numbering follows the DES standard: bit 1 is the MSB of every vector.
package des_key_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DES_ROUNDS = 16;
    localparam logic [3:0]  LAST_ROUND = 4'(DES_ROUNDS - 1);

    // Read request into the subkey store.
    typedef struct packed {
        logic [3:0] idx;
        logic       decrypt;
    } sk_rd_req_t;

    // Left-rotate amount per round; sums to 28 so C/D return to PC-1(key).
    localparam logic [1:0] SHIFT_TAB [DES_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC-1: 64-bit key -> 56-bit C||D (parity bits 8,16,..,64 dropped).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: 56-bit C||D -> 48-bit round subkey.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [1:28] rotl28(input logic [1:28] x, input logic [1:0] n);
        logic [1:28] r;
        case (n)
            2'd1:    r = {x[2:28], x[1]};
            2'd2:    r = {x[3:28], x[1:2]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[i+1] = k[PC1_TAB[i]];
        return r;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[i+1] = cd[PC2_TAB[i]];
        return r;
    endfunction

    // Every key byte must carry an odd number of ones.
    function automatic logic key_parity_ok(input logic [1:64] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) ok = ok & (^k[b*8+1 +: 8]);
        return ok;
    endfunction

endpackage

// File: rtl/des_key_sched_ctrl_subgen.sv
// des_subkey_gen
//   Combinational round step: rotates C and D by the round's shift amount
//   and forms the 48-bit PC-2 subkey from the rotated halves.
//   Ports:
//     c, d         in   current 28-bit halves
//     shift        in   rotate amount (1 or 2)
//     c_rot, d_rot out  rotated halves (next C/D)
//     subkey       out  PC-2(c_rot || d_rot)
module des_subkey_gen
    import des_key_pkg::*;
(
    input  logic [1:28] c,
    input  logic [1:28] d,
    input  logic [1:0]  shift,
    output logic [1:28] c_rot,
    output logic [1:28] d_rot,
    output logic [1:48] subkey
);

    always_comb begin
        c_rot  = rotl28(c, shift);
        d_rot  = rotl28(d, shift);
        subkey = pc2({c_rot, d_rot});
    end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl
//   DES key schedule sequencer and 16-entry subkey store. A key accepted on
//   the valid/ready handshake is loaded through PC-1, then one round per
//   cycle is rotated and PC-2'd into entry[round]. Subkeys are read back by
//   round index, forward or reversed, through a registered read port.
//   Optional build macro: DES_KEY_PARITY_CHK_EN enables odd-parity checking
//   of offered keys; without it parity bits are ignored and parity_err is 0.
//   Ports:
//     clk, rst     clock, async active-high reset
//     key_in       64-bit key (bit 1 = MSB)
//     key_valid    key presented
//     key_ready    key accepted this cycle if valid (IDLE/DONE)
//     sk_idx       round index 0..15
//     sk_decrypt   1 = read entry 15-sk_idx
//     sk_out       registered subkey read
//     sched_ready  all 16 entries valid for the last accepted key
//     busy         generation in progress
//     parity_err   last offered key had a bad parity byte
module des_key_sched_ctrl
    import des_key_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:64] key_in,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [3:0]  sk_idx,
    input  logic        sk_decrypt,
    output logic [1:48] sk_out,
    output logic        sched_ready,
    output logic        busy,
    output logic        parity_err
);

    state_t       state_q, state_d;
    logic [3:0]   round_q;
    logic [1:28]  c_q, d_q;
    logic [1:28]  c_rot, d_rot;
    logic [1:48]  subkey;
    logic [1:48]  rf [DES_ROUNDS];
    logic         hs, key_bad, load;
    sk_rd_req_t   rd_req;
    logic [3:0]   rd_idx;

`ifdef DES_KEY_PARITY_CHK_EN
    logic parity_err_q;

    assign key_bad = ~key_parity_ok(key_in);

    // Bad key is still consumed; the flag tracks the most recent handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     parity_err_q <= 1'b0;
        else if (hs) parity_err_q <= key_bad;
    end

    assign parity_err = parity_err_q;
`else
    assign key_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign hs   = key_valid && key_ready;
    assign load = hs && !key_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and status outputs. Handshake is derived from state here
    // rather than from key_ready to keep this block free of self-reads.
    always_comb begin
        state_d     = state_q;
        key_ready   = (state_q != GEN);
        busy        = (state_q == GEN);
        sched_ready = (state_q == DONE);
        case (state_q)
            IDLE, DONE: if (key_valid) state_d = key_bad ? IDLE : GEN;
            GEN:        if (round_q == LAST_ROUND) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    des_subkey_gen u_subgen (
        .c      (c_q),
        .d      (d_q),
        .shift  (SHIFT_TAB[round_q]),
        .c_rot  (c_rot),
        .d_rot  (d_rot),
        .subkey (subkey)
    );

    assign rd_req = '{idx: sk_idx, decrypt: sk_decrypt};
    // 15 - idx
    assign rd_idx = rd_req.decrypt ? ~rd_req.idx : rd_req.idx;

    // Register file is deliberately not cleared on a new key: entries not yet
    // rewritten keep the previous schedule until their round comes up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            sk_out  <= '0;
            for (int i = 0; i < DES_ROUNDS; i++) rf[i] <= '0;
        end else begin
            sk_out <= rf[rd_idx];
            if (load) begin
                {c_q, d_q} <= pc1(key_in);
                round_q    <= '0;
            end else if (state_q == GEN) begin
                c_q         <= c_rot;
                d_q         <= d_rot;
                rf[round_q] <= subkey;
                if (round_q != LAST_ROUND) round_q <= round_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// tb_des_key_sched_ctrl
//   Directed bench for des_key_sched_ctrl with hand-computed DES subkeys.
module tb_des_key_sched_ctrl;

    localparam logic [63:0] KEY_STD  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_WEAK = 64'h0101010101010101;
    localparam logic [63:0] KEY_ONES = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] KEY_ZERO = 64'h0000000000000000;
    localparam logic [47:0] K1_STD   = 48'h1B02EFFC7072;
    localparam logic [47:0] K2_STD   = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16_STD  = 48'hCB3D8B0E17F5;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:64] key_in;
    logic        key_valid;
    logic        key_ready;
    logic [3:0]  sk_idx;
    logic        sk_decrypt;
    logic [1:48] sk_out;
    logic        sched_ready;
    logic        busy;
    logic        parity_err;

    int checks = 0;
    int errors = 0;
    int nrdy;
    logic [47:0] v;

    always #5 clk = ~clk;

    des_key_sched_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .sk_idx      (sk_idx),
        .sk_decrypt  (sk_decrypt),
        .sk_out      (sk_out),
        .sched_ready (sched_ready),
        .busy        (busy),
        .parity_err  (parity_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves key_valid high; returns just after the handshake edge.
    task automatic send_key(input logic [63:0] k);
        int n;
        n = 0;
        key_in    = k;
        key_valid = 1'b1;
        while (!key_ready && n < 40) begin
            tick();
            n++;
        end
        chk("send_rdy", key_ready, 1'b1);
        tick();
    endtask

    task automatic read_sk(input logic [3:0] idx, input logic dec, output logic [47:0] val);
        sk_idx     = idx;
        sk_decrypt = dec;
        tick();
        val = sk_out;
    endtask

    initial begin
        rst = 1'b1;
        key_valid = 1'b0;
        key_in = '0;
        sk_idx = '0;
        sk_decrypt = 1'b0;
        #3;
        chk("rst_sk_out", sk_out, 48'h0);
        chk("rst_kready", key_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sched", sched_ready, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Standard key; a different key held valid throughout GEN is ignored.
        send_key(KEY_STD);
        key_in = KEY_ONES;
        chk("a_busy0", busy, 1'b1);
        nrdy = 0;
        for (int i = 0; i < 16; i++) begin
            if (!key_ready) nrdy++;
            tick();
        end
        key_valid = 1'b0;
        chk("a_nrdy16", nrdy, 16);
        chk("a_sched", sched_ready, 1'b1);
        chk("a_kready", key_ready, 1'b1);
        chk("a_busy", busy, 1'b0);
        chk("a_c_pc1", dut.c_q, 28'hF0CCAAF);
        chk("a_d_pc1", dut.d_q, 28'h556678F);
        read_sk(4'd0, 1'b0, v);  chk("a_k1", v, K1_STD);
        read_sk(4'd1, 1'b0, v);  chk("a_k2", v, K2_STD);
        read_sk(4'd15, 1'b0, v); chk("a_k16", v, K16_STD);
        read_sk(4'd0, 1'b1, v);  chk("a_dec0", v, K16_STD);
        read_sk(4'd14, 1'b1, v); chk("a_dec14", v, K2_STD);

        // Weak key: all subkeys zero; exact sched_ready timing.
        send_key(KEY_WEAK);
        key_valid = 1'b0;
        repeat (15) tick();
        chk("b_sched_early", sched_ready, 1'b0);
        tick();
        chk("b_sched", sched_ready, 1'b1);
        for (int r = 0; r < 16; r++) begin
            read_sk(4'(r), 1'b0, v);
            chk("b_zero", v, 48'h0);
        end

        // Back-to-back: second key accepted in the first DONE cycle.
        send_key(KEY_ONES);
        key_in = KEY_STD;
        repeat (16) tick();
        chk("c_sched1", sched_ready, 1'b1);
        tick();
        key_valid = 1'b0;
        chk("c_sched_drop", sched_ready, 1'b0);
        chk("c_busy", busy, 1'b1);
        read_sk(4'd15, 1'b0, v); chk("c_old15", v, 48'hFFFFFFFFFFFF);
        read_sk(4'd0, 1'b0, v);  chk("c_new0", v, K1_STD);
        repeat (13) tick();
        chk("c_sched_early", sched_ready, 1'b0);
        tick();
        chk("c_sched2", sched_ready, 1'b1);
        read_sk(4'd15, 1'b0, v); chk("c_k16", v, K16_STD);

`ifdef DES_KEY_PARITY_CHK_EN
        send_key(KEY_ZERO);
        key_valid = 1'b0;
        chk("e_perr", parity_err, 1'b1);
        chk("e_sched", sched_ready, 1'b0);
        chk("e_busy", busy, 1'b0);
        chk("e_kready", key_ready, 1'b1);
        tick();
        chk("e_perr_hold", parity_err, 1'b1);
        send_key(KEY_STD);
        key_valid = 1'b0;
        chk("e_perr_clr", parity_err, 1'b0);
        chk("e_busy2", busy, 1'b1);
        repeat (16) tick();
        chk("e_sched2", sched_ready, 1'b1);
        read_sk(4'd0, 1'b0, v); chk("e_k1", v, K1_STD);
`else
        send_key(KEY_ZERO);
        key_valid = 1'b0;
        chk("e_perr_off", parity_err, 1'b0);
        chk("e_busy", busy, 1'b1);
        repeat (16) tick();
        chk("e_sched", sched_ready, 1'b1);
        read_sk(4'd7, 1'b0, v); chk("e_zero7", v, 48'h0);
`endif

        // Reset in the middle of generation.
        send_key(KEY_STD);
        key_valid  = 1'b0;
        sk_idx     = 4'd15;
        sk_decrypt = 1'b1;
        repeat (7) tick();
        chk("d_pre_sk", sk_out, K1_STD);
        chk("d_pre_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("d_sk_out", sk_out, 48'h0);
        chk("d_busy", busy, 1'b0);
        chk("d_kready", key_ready, 1'b1);
        chk("d_sched", sched_ready, 1'b0);
        chk("d_perr", parity_err, 1'b0);
        #1 rst = 1'b0;
        tick();
        chk("d_rf_clr", sk_out, 48'h0);
        chk("d_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
